// File: rtl/neuron_mac.sv
// neuron_mac: Q16.16 multiply-accumulate neuron with ReLU output and derivative.
// Define ACC_SAT_EN to saturate the accumulator instead of wrapping it.
module neuron_mac #(
    parameter int unsigned N_IN = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] bias,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] w,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        d,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUT
    } state_e;

    localparam int unsigned     CNT_W = 16;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);

    state_e             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        y_q, y_d;
    logic               deriv_q, deriv_d;

    logic signed [63:0] prod;
    logic signed [63:0] prod_rnd;
    logic [31:0]        p;
    logic [31:0]        sum;
    logic               sum_pos;
    logic               unused_prod_bits;

    // Adding half an LSB before truncation gives round-half-up on bits [47:16].
    assign prod             = $signed(a) * $signed(w);
    assign prod_rnd         = prod + 64'sh8000;
    assign p                = prod_rnd[47:16];
    assign unused_prod_bits = ^{prod_rnd[63:48], prod_rnd[15:0]};

`ifdef ACC_SAT_EN
    logic [31:0] raw_sum;
    logic        ovf;

    assign raw_sum = acc_q + p;
    assign ovf     = (acc_q[31] == p[31]) && (raw_sum[31] != acc_q[31]);
    assign sum     = !ovf ? raw_sum : (acc_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF);
`else
    assign sum = acc_q + p;
`endif

    assign sum_pos = !sum[31] && (sum != 32'd0);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        deriv_d = deriv_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = bias;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        y_d     = sum_pos ? sum : 32'd0;
                        deriv_d = sum_pos;
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            deriv_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            deriv_q <= deriv_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign y         = y_q;
    assign d         = deriv_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: three instances (N_IN = 1, 2, 4) against a
// transaction-level arithmetic model; define ACC_SAT_EN to match a saturating build.
`timescale 1ns/1ps
module tb_neuron_mac;

    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [ND-1:0]       start_s, in_valid_s, in_ready_s, out_valid_s, out_ready_s, d_s, busy_s;
    logic [ND-1:0][31:0] bias_s, a_s, w_s, y_s;

    int checks   = 0;
    int failures = 0;

    genvar g;
    generate
        for (g = 0; g < ND; g++) begin : g_dut
            neuron_mac #(.N_IN(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .start    (start_s[g]),
                .bias     (bias_s[g]),
                .in_valid (in_valid_s[g]),
                .in_ready (in_ready_s[g]),
                .a        (a_s[g]),
                .w        (w_s[g]),
                .out_valid(out_valid_s[g]),
                .out_ready(out_ready_s[g]),
                .y        (y_s[g]),
                .d        (d_s[g]),
                .busy     (busy_s[g])
            );
        end
    endgenerate

    function automatic int n_of(int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    // Rounded product: floor(a*w / 2^16 + 1/2), reduced to 32 bits.
    function automatic logic [31:0] prod_term(logic [31:0] av, logic [31:0] wv);
        longint pr = longint'($signed(av)) * longint'($signed(wv));
        return 32'((pr + 32768) >>> 16);
    endfunction

    function automatic logic [31:0] acc_add(logic [31:0] x, logic [31:0] pv);
        longint s = longint'($signed(x)) + longint'($signed(pv));
`ifdef ACC_SAT_EN
        longint maxv = 2147483647;
        longint minv = -longint'(2147483647) - 1;
        if (s > maxv) s = maxv;
        else if (s < minv) s = minv;
`endif
        return 32'(s);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: one evaluation in flight per instance.
    logic [ND-1:0] m_active, m_done, m_d;
    int            m_k   [ND];
    logic [31:0]   m_acc [ND];
    logic [31:0]   m_y   [ND];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < ND; i++) begin
            if (!rst_n) begin
                m_active[i] <= 1'b0;
                m_done[i]   <= 1'b0;
                m_d[i]      <= 1'b0;
                m_k[i]      <= 0;
                m_acc[i]    <= '0;
                m_y[i]      <= '0;
            end else if (m_done[i]) begin
                if (out_ready_s[i]) begin
                    m_done[i]   <= 1'b0;
                    m_active[i] <= 1'b0;
                end
            end else if (m_active[i]) begin
                if (in_valid_s[i]) begin
                    m_acc[i] <= acc_add(m_acc[i], prod_term(a_s[i], w_s[i]));
                    m_k[i]   <= m_k[i] + 1;
                    if (m_k[i] + 1 == n_of(i)) begin
                        m_done[i] <= 1'b1;
                        m_y[i]    <= ($signed(acc_add(m_acc[i], prod_term(a_s[i], w_s[i]))) > 0)
                                     ? acc_add(m_acc[i], prod_term(a_s[i], w_s[i])) : 32'd0;
                        m_d[i]    <= ($signed(acc_add(m_acc[i], prod_term(a_s[i], w_s[i]))) > 0);
                    end
                end
            end else if (start_s[i]) begin
                m_active[i] <= 1'b1;
                m_acc[i]    <= bias_s[i];
                m_k[i]      <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < ND; i++) begin
                check($sformatf("in_ready[%0d]", i), 32'(in_ready_s[i]), 32'(m_active[i] && !m_done[i]));
                check($sformatf("out_valid[%0d]", i), 32'(out_valid_s[i]), 32'(m_done[i]));
                check($sformatf("busy[%0d]", i), 32'(busy_s[i]), 32'(m_active[i]));
                if (m_done[i]) begin
                    check($sformatf("y[%0d]", i), y_s[i], m_y[i]);
                    check($sformatf("d[%0d]", i), 32'(d_s[i]), 32'(m_d[i]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        for (int i = 0; i < ND; i++) begin
            check($sformatf("rst_in_ready[%0d]", i), 32'(in_ready_s[i]), 32'd0);
            check($sformatf("rst_out_valid[%0d]", i), 32'(out_valid_s[i]), 32'd0);
            check($sformatf("rst_busy[%0d]", i), 32'(busy_s[i]), 32'd0);
            check($sformatf("rst_y[%0d]", i), y_s[i], 32'd0);
            check($sformatf("rst_d[%0d]", i), 32'(d_s[i]), 32'd0);
        end
    endtask

    task automatic do_start(input int i, input logic [31:0] b);
        start_s[i] = 1'b1;
        bias_s[i]  = b;
        tick();
        start_s[i] = 1'b0;
        bias_s[i]  = $urandom;
    endtask

    task automatic feed(input int i, input logic [31:0] av, input logic [31:0] wv, input int gap);
        repeat (gap) begin
            in_valid_s[i] = 1'b0;
            start_s[i]    = 1'($urandom_range(0, 1));
            a_s[i]        = $urandom;
            w_s[i]        = $urandom;
            tick();
        end
        in_valid_s[i] = 1'b1;
        start_s[i]    = 1'($urandom_range(0, 1));
        a_s[i]        = av;
        w_s[i]        = wv;
        tick();
        in_valid_s[i] = 1'b0;
        start_s[i]    = 1'b0;
    endtask

    task automatic finish_out(input int i, input int hold);
        int budget = 0;
        while (!out_valid_s[i] && budget < 50) begin
            tick();
            budget++;
        end
        if (!out_valid_s[i]) check($sformatf("out_timeout[%0d]", i), 32'd0, 32'd1);
        repeat (hold) begin
            start_s[i] = 1'($urandom_range(0, 1));
            bias_s[i]  = $urandom;
            tick();
        end
        start_s[i]     = 1'($urandom_range(0, 1));
        out_ready_s[i] = 1'b1;
        tick();
        out_ready_s[i] = 1'b0;
        start_s[i]     = 1'b0;
    endtask

    function automatic logic [31:0] rand_val();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 2))
            0:       return r;
            1:       return {{12{r[19]}}, r[19:0]};
            default: return {{16{r[15]}}, r[15:0]};
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        start_s     = '0;
        in_valid_s  = '0;
        out_ready_s = '0;
        bias_s      = '0;
        a_s         = '0;
        w_s         = '0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset();

        // Release reset and request a start for the very first edge.
        rst_n = 1'b1;
        do_start(1, 32'h0000_8000);
        check("first_edge_start_busy", 32'(busy_s[1]), 32'd1);

        // 0.5 + 2*1.5 + (-1)*1 = 2.5
        feed(1, 32'h0002_0000, 32'h0001_8000, 0);
        feed(1, 32'hFFFF_0000, 32'h0001_0000, 0);
        check("n2_out_valid", 32'(out_valid_s[1]), 32'd1);
        check("n2_y", y_s[1], 32'h0002_8000);
        check("n2_d", 32'(d_s[1]), 32'd1);
        finish_out(1, 0);

        // -2 + 1 = -1 clamps to zero
        do_start(0, 32'hFFFE_0000);
        feed(0, 32'h0001_0000, 32'h0001_0000, 0);
        check("neg_y", y_s[0], 32'd0);
        check("neg_d", 32'(d_s[0]), 32'd0);
        finish_out(0, 0);

        // Product of 2^-16 * 0.5 rounds up to one LSB
        do_start(0, 32'd0);
        feed(0, 32'h0000_0001, 32'h0000_8000, 0);
        check("round_y", y_s[0], 32'h0000_0001);
        check("round_d", 32'(d_s[0]), 32'd1);
        finish_out(0, 0);

        // Overflow of 32767 + 1
        do_start(0, 32'h7FFF_0000);
        feed(0, 32'h0001_0000, 32'h0001_0000, 0);
`ifdef ACC_SAT_EN
        check("ovf_y", y_s[0], 32'h7FFF_FFFF);
        check("ovf_d", 32'(d_s[0]), 32'd1);
`else
        check("ovf_y", y_s[0], 32'd0);
        check("ovf_d", 32'(d_s[0]), 32'd0);
`endif
        finish_out(0, 0);

        // Result held under backpressure with start pulses ignored: 3 + 2*2 = 7
        do_start(0, 32'h0003_0000);
        feed(0, 32'h0002_0000, 32'h0002_0000, 0);
        for (int k = 0; k < 5; k++) begin
            start_s[0] = 1'b1;
            bias_s[0]  = $urandom;
            tick();
            check("hold_out_valid", 32'(out_valid_s[0]), 32'd1);
            check("hold_y", y_s[0], 32'h0007_0000);
            check("hold_d", 32'(d_s[0]), 32'd1);
        end
        out_ready_s[0] = 1'b1;
        start_s[0]     = 1'b1;
        tick();
        out_ready_s[0] = 1'b0;
        check("handshake_idle_busy", 32'(busy_s[0]), 32'd0);
        check("handshake_idle_valid", 32'(out_valid_s[0]), 32'd0);
        do_start(0, 32'd0);
        check("restart_after_idle_busy", 32'(busy_s[0]), 32'd1);
        feed(0, 32'h0001_0000, 32'h0001_0000, 0);
        check("restart_y", y_s[0], 32'h0001_0000);
        finish_out(0, 0);

        // Abort a partial evaluation with reset, then run a clean one: 4 * 1 = 4
        do_start(2, 32'h0010_0000);
        feed(2, 32'h0001_0000, 32'h0001_0000, 0);
        feed(2, 32'h0001_0000, 32'h0001_0000, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_start(2, 32'd0);
        for (int k = 0; k < 4; k++) feed(2, 32'h0001_0000, 32'h0001_0000, 0);
        check("abort_fresh_valid", 32'(out_valid_s[2]), 32'd1);
        check("abort_fresh_y", y_s[2], 32'h0004_0000);
        finish_out(2, 1);

        // Randomized evaluations across all instances
        for (int t = 0; t < 60; t++) begin
            int i = $urandom_range(0, ND - 1);
            do_start(i, rand_val());
            for (int k = 0; k < n_of(i); k++) feed(i, rand_val(), rand_val(), $urandom_range(0, 2));
            finish_out(i, $urandom_range(0, 3));
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter: N_IN, 16, number of (activation, weight) pairs accumulated per neuron evaluation (legal range 1..65535).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  begin a neuron evaluation; honoured only in IDLE.
REQ-005 SHALL have port: bias  input  32  signed Q16.16 bias, sampled on the accepted start cycle.
REQ-006 SHALL have port: in_valid  input  1  a/w pair present.
REQ-007 SHALL have port: in_ready  output  1  block accepts a pair this cycle.
REQ-008 SHALL have port: a  input  32  signed Q16.16 activation.
REQ-009 SHALL have port: w  input  32  signed Q16.16 weight.
REQ-010 SHALL have port: out_valid  output  1  result y/d valid.
REQ-011 SHALL have port: out_ready  input  1  downstream consumes result.
REQ-012 SHALL have port: y  output  32  signed Q16.16 ReLU of the final sum.
REQ-013 SHALL have port: d  output  1  ReLU derivative, 1 iff final sum > 0.
REQ-014 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM, OUT.
REQ-016 IDLE: start=1 -> acc <= bias, cnt <= 0, next state ACCUM.
REQ-017 ACCUM: in_ready SHALL be 1; in_ready SHALL be 0 in IDLE and OUT.
REQ-018 A pair SHALL be accepted only when in_valid && in_ready in the same cycle; no accept otherwise, acc and cnt hold.
REQ-019 On accept: acc <= acc + p, where p = bits [47:16] of the 64-bit signed product a*w plus bit [15] of that product (round-half-up), cnt <= cnt+1.
REQ-020 Adds SHALL be 32-bit two's complement wrap (unless ACC_SAT_EN, REQ-031).
REQ-021 On the accept with cnt == N_IN-1: y <= (sum>0 ? sum : 0), d <= (sum>0), next state OUT; sum = acc + p of that cycle.
REQ-022 Latency: out_valid SHALL rise in the cycle after the last pair is accepted; N_IN=1 SHALL give OUT one cycle after its single accept.
REQ-023 OUT: out_valid=1; y and d SHALL stay stable until out_valid && out_ready; then next state IDLE.
REQ-024 start asserted in ACCUM or OUT SHALL be ignored; no restart, no bias resample.
REQ-025 start in the same cycle as the out handshake SHALL be ignored; a new start is honoured no earlier than the following cycle (IDLE).
REQ-026 Back-to-back throughput: one pair per cycle while in_valid held high.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, acc=0, cnt=0, y=0, d=0, out_valid=0, in_ready=0, busy=0.
REQ-028 Reset asserted during ACCUM or OUT SHALL discard the partial sum; no out_valid SHALL follow for the aborted evaluation.
REQ-029 After rst_n deassertion the block SHALL accept start on the first rising edge.

Configuration
REQ-030 Macro ACC_SAT_EN SHALL select the accumulate overflow behaviour.
REQ-031 ACC_SAT_EN defined: each acc + p SHALL saturate to 0x7FFFFFFF on positive overflow and 0x80000000 on negative overflow; product p itself is not saturated.
REQ-032 ACC_SAT_EN undefined: plain wrapping 32-bit add; all other behaviour identical.

Verification
REQ-033 N_IN=2, bias=0x00008000, pairs (0x00020000,0x00018000),(0xFFFF0000,0x00010000) -> one cycle after 2nd accept out_valid=1, y=0x00028000, d=1.
REQ-034 N_IN=1, bias=0xFFFE0000, pair (0x00010000,0x00010000) -> y=0x00000000, d=0.
REQ-035 N_IN=1, bias=0, pair (0x00000001,0x00008000) -> y=0x00000001 (rounding bit), d=1.
REQ-036 N_IN=1, bias=0x7FFF0000, pair (0x00010000,0x00010000) -> without ACC_SAT_EN y=0, d=0; with ACC_SAT_EN y=0x7FFFFFFF, d=1.
REQ-037 out_ready held low 5 cycles in OUT, start pulsed meanwhile -> y/d/out_valid stable, no restart; out_ready=1 -> IDLE next cycle.
REQ-038 N_IN=4, rst_n pulsed low after 2 accepts, then fresh evaluation -> out_valid never rises for aborted run; new result excludes old partial sum.
